// File: rtl/line_rotation_pkg.sv
// Shared definitions for the line rotation key path: LFSR polynomial, reset seed,
// scheduler states and the single-step LFSR function used by RTL and bench alike.
package line_rotation_pkg;

  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0] RESET_SEED = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } state_e;

  // Galois right-shift step; feedback taps applied when the outgoing bit is 1.
  function automatic logic [31:0] step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR with load, step and combined load-and-step.
module lfsr32_galois
  import line_rotation_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_load_val,
  output logic [31:0] o_value
);

  logic [31:0] r_value;
  logic [31:0] w_value_d;

  // Load-and-step lets a reseed and the first active line share one edge.
  always_comb begin
    w_value_d = r_value;
    if (i_load && i_step) begin
      w_value_d = step(i_load_val);
    end else if (i_load) begin
      w_value_d = i_load_val;
    end else if (i_step) begin
      w_value_d = step(r_value);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= RESET_SEED;
    end else begin
      r_value <= w_value_d;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/cut_position_scheduler.sv
// Per-line cut key generator: tracks BT.656 H/V/F timing, reseeds the LFSR at each
// field-1 start and steps it once per active line so both link ends stay in lockstep.
module cut_position_scheduler
  import line_rotation_pkg::*;
#(
  parameter int unsigned CUT_WIDTH = 8,
  parameter int unsigned MAX_LINES = 525
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 H,
  input  logic                 V,
  input  logic                 F,
  input  logic [31:0]          key,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic [CUT_WIDTH-1:0] raw_cut_position,
  output logic                 cut_valid,
  output logic [9:0]           active_line,
  output logic                 sync_lost
);

  logic                 r_prev_h, r_prev_v;
  logic                 w_h_rise, w_frame_start;
  logic [31:0]          r_seed, r_pend_key;
  logic                 r_pend_valid;
  logic [31:0]          w_seed_d, w_pend_key_d, w_seed_eff;
  logic                 w_pend_valid_d, w_key_fire;
  state_e               r_state, w_state_d;
  logic [CUT_WIDTH-1:0] r_cut, w_cut_d, w_cut_next;
  logic                 r_cut_valid, w_cut_valid_d;
  logic [9:0]           r_active_line, w_active_line_d;
  logic [9:0]           r_line_cnt, w_line_cnt_d;
  logic                 r_sync_lost, w_sync_lost_d;
  logic                 w_lfsr_load, w_lfsr_step;
  logic [31:0]          w_lfsr_val, w_lfsr_next;

  assign w_h_rise      = H & ~r_prev_h;
  assign w_frame_start = ~V & r_prev_v & ~F;

  // The slot frees on frame_start, so a key offered in that cycle is taken immediately.
  assign key_ready  = ~r_pend_valid | w_frame_start;
  assign w_key_fire = key_valid & key_ready;
  assign w_seed_eff = r_pend_valid ? r_pend_key : r_seed;

  // Value the LFSR holds after this edge if it steps; reseed takes precedence.
  assign w_lfsr_next = w_frame_start ? step(w_seed_eff) : step(w_lfsr_val);
  assign w_cut_next  = CUT_WIDTH'(w_lfsr_next);

  lfsr32_galois u_lfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_lfsr_load),
    .i_step     (w_lfsr_step),
    .i_load_val (w_seed_eff),
    .o_value    (w_lfsr_val)
  );

  // Key slot: promote pending key at frame_start, then accept a new offer.
  always_comb begin
    w_seed_d       = r_seed;
    w_pend_key_d   = r_pend_key;
    w_pend_valid_d = r_pend_valid;
    if (w_frame_start && r_pend_valid) begin
      w_seed_d       = r_pend_key;
      w_pend_valid_d = 1'b0;
    end
    if (w_key_fire) begin
      w_pend_key_d   = (key == 32'h0) ? RESET_SEED : key;
      w_pend_valid_d = 1'b1;
    end
  end

  // Next state and output register values for the line scheduler.
  always_comb begin
    w_state_d       = r_state;
    w_cut_d         = r_cut;
    w_cut_valid_d   = r_cut_valid;
    w_active_line_d = r_active_line;
    w_line_cnt_d    = r_line_cnt;
    w_sync_lost_d   = 1'b0;
    w_lfsr_load     = 1'b0;
    w_lfsr_step     = 1'b0;
    if (!enable) begin
      w_state_d       = IDLE;
      w_cut_d         = '0;
      w_cut_valid_d   = 1'b0;
      w_active_line_d = '0;
      w_line_cnt_d    = '0;
    end else begin
      unique case (r_state)
        IDLE: w_state_d = WAIT_FRAME;
        WAIT_FRAME, RUN: begin
          if (w_frame_start) begin
            w_state_d       = RUN;
            w_lfsr_load     = 1'b1;
            w_active_line_d = '0;
            w_line_cnt_d    = '0;
            if (w_h_rise) begin
              w_lfsr_step     = 1'b1;
              w_cut_d         = w_cut_next;
              w_cut_valid_d   = 1'b1;
              w_active_line_d = 10'd1;
              w_line_cnt_d    = 10'd1;
            end
          end else if (r_state == RUN && w_h_rise) begin
            if (32'(r_line_cnt) >= MAX_LINES) begin
              // This h_rise pushes the count past MAX_LINES: timing is lost.
              w_state_d       = WAIT_FRAME;
              w_sync_lost_d   = 1'b1;
              w_cut_d         = '0;
              w_cut_valid_d   = 1'b0;
              w_active_line_d = '0;
              w_line_cnt_d    = '0;
            end else begin
              w_line_cnt_d = r_line_cnt + 10'd1;
              if (!V) begin
                w_lfsr_step     = 1'b1;
                w_cut_d         = w_cut_next;
                w_cut_valid_d   = 1'b1;
                w_active_line_d = (r_active_line == 10'h3FF) ? r_active_line
                                                             : r_active_line + 10'd1;
              end else begin
                w_cut_valid_d = 1'b0;
              end
            end
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  // State, edge-detect, key slot and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_h      <= 1'b0;
      r_prev_v      <= 1'b1;
      r_seed        <= RESET_SEED;
      r_pend_key    <= '0;
      r_pend_valid  <= 1'b0;
      r_state       <= IDLE;
      r_cut         <= '0;
      r_cut_valid   <= 1'b0;
      r_active_line <= '0;
      r_line_cnt    <= '0;
      r_sync_lost   <= 1'b0;
    end else begin
      r_prev_h      <= H;
      r_prev_v      <= V;
      r_seed        <= w_seed_d;
      r_pend_key    <= w_pend_key_d;
      r_pend_valid  <= w_pend_valid_d;
      r_state       <= w_state_d;
      r_cut         <= w_cut_d;
      r_cut_valid   <= w_cut_valid_d;
      r_active_line <= w_active_line_d;
      r_line_cnt    <= w_line_cnt_d;
      r_sync_lost   <= w_sync_lost_d;
    end
  end

  assign raw_cut_position = r_cut;
  assign cut_valid        = r_cut_valid;
  assign active_line      = r_active_line;
  assign sync_lost        = r_sync_lost;

endmodule

// File: doc/cut_position_scheduler.md
# cut_position_scheduler

Generates the per-line `raw_cut_position` key that drives `line_rotator` (scrambler and descrambler alike) from a shared 32-bit seed. It tracks BT.656 timing through the `H`/`V`/`F` flags from `sync_parser`. On every active-line start it steps an LFSR, and it reseeds at each frame start so both ends stay in lockstep. It sits between `sync_parser` and `line_rotator`, and accepts new keys from the control plane through a valid/ready handshake.

## Interface
- `CUT_WIDTH`, 8: width of `raw_cut_position`; equals the LSBs of the LFSR.
- `MAX_LINES`, 525: H-rise count between frame starts beyond which sync is declared lost.
- `clk` in 1: video clock (27 MHz BT.656 byte clock).
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `enable` in 1: run request; 0 forces IDLE.
- `H`, `V`, `F` in 1 each: sync flags from `sync_parser`.
- `key` in 32: new seed.
- `key_valid` in 1: `key` is offered.
- `key_ready` out 1: pending-key slot is free.
- `raw_cut_position` out CUT_WIDTH: cut for the current line, to `line_rotator`.
- `cut_valid` out 1: `raw_cut_position` belongs to a keyed active line.
- `active_line` out 10: active lines since frame start, saturating at 1023.
- `sync_lost` out 1: one-cycle pulse on sync loss.

## Operation
- Edge detect uses registers `prev_H` and `prev_V`:
  - `h_rise = H & ~prev_H`
  - `frame_start = ~V & prev_V & ~F` (field-1 active region begins)
- Seed register: 32 bits. Pending slot: 32 bits plus a valid bit.
  - Handshake fires when `key_valid & key_ready`. It fills the pending slot; `key_ready = ~pending_valid`.
  - The pending key moves to the seed register at the next `frame_start`, which frees the slot.
  - A key of 0 is stored as 32'h1.
  - Reset value of the seed register is 32'h1.
- LFSR step (Galois, right shift): `step(x) = x[0] ? (x>>1) ^ 32'h8020_0003 : x>>1`.
- States:
  - IDLE -> WAIT_FRAME when `enable`.
  - WAIT_FRAME -> RUN on `frame_start`.
  - RUN -> WAIT_FRAME on sync loss.
  - Any state -> IDLE when `!enable`.
- In RUN:
  - On `frame_start`: LFSR <= seed (pending key applied first if present) and `active_line` <= 0.
  - On `h_rise & ~V`: LFSR steps once, `raw_cut_position` <= next LFSR[CUT_WIDTH-1:0], `cut_valid` <= 1, `active_line` increments.
  - If `frame_start` and `h_rise` coincide: LFSR <= step(seed), so the first active cut is step(seed) LSBs. `active_line` <= 1.
  - On `h_rise` while `V=1`: LFSR and cut hold; `cut_valid` <= 0.
- Line counter counts every `h_rise` since the last `frame_start`. When it exceeds MAX_LINES: pulse `sync_lost`, clear `cut_valid`, go to WAIT_FRAME.
- In IDLE and WAIT_FRAME: `cut_valid=0` and `raw_cut_position` holds 0.

## Timing
- Reset values:
  - `raw_cut_position=0`, `cut_valid=0`, `active_line=0`, `sync_lost=0`, `key_ready=1`
  - LFSR = 32'h1; state IDLE
  - `prev_H=0`, `prev_V=1`, so no false `frame_start` fires on the first sample.
- Latency: `h_rise` is detected in the cycle H is first sampled 1. `raw_cut_position` is updated by that same clock edge, i.e. valid one cycle after H first appears. It stays stable for the whole line.
- A handshake in the same cycle as `frame_start`: the old pending key (if any) is applied and the new key is captured into the freed slot. If no key was pending, the incoming key waits for the next frame.
- Deasserting `enable` mid-line: outputs return to reset values on the next edge; the seed and pending slot are kept.
- Asynchronous reset mid-frame: everything returns to reset values immediately, and the block resynchronises at the next `frame_start` after `enable`.

## Structure
- Shared package `line_rotation_pkg`:
  - LFSR polynomial constant 32'h8020_0003
  - reset seed 32'h1
  - state enum {IDLE, WAIT_FRAME, RUN}
  - `step()` function, reused by the bench model
- One sub-module `lfsr32_galois`: load, step, load-and-step in one cycle, and value out.

## Test plan
- Key 32'h2A loaded, enable, frame with 3 active lines -> cuts 0x15, 0x09, 0x07 with `cut_valid=1`; `active_line` = 1, 2, 3.
- Key 0 loaded -> stored as 32'h1; first active cut = 0x03.
- Second key offered while one is pending -> `key_ready=0` until the next `frame_start`. Second frame uses the first key, third frame uses the second key.
- `h_rise` lines during `V=1` -> cut holds and `cut_valid=0`. Next frame repeats the same cut sequence (per-frame reseed).
- Drop `V` so 600 `h_rise` occur with no `frame_start` -> `sync_lost` pulses once at the 526th, then WAIT_FRAME with `cut_valid=0`.
- `reset_n` asserted mid-line, and separately `enable` dropped mid-line -> all outputs return to reset values. Sequence restarts at step(seed) on the next frame.
